y86_fetch_stage: RTL and testbench

Y86_FETCH_STAGE -- requirements
Module: y86_fetch_stage

---
 rtl/y86_pkg.sv | 35 +++
 rtl/y86_fetch_stage_if.sv | 40 ++++
 rtl/y86_fetch_align.sv | 22 ++
 rtl/y86_fetch_stage.sv | 50 +++++
 tb/tb_y86_fetch_stage.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Y86-64 instruction codes, the "no register" specifier and format helpers
// shared by the fetch stage and its sub-module.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  function automatic logic need_regids_f(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: need_regids_f = 1'b1;
      default:                need_regids_f = 1'b0;
    endcase
  endfunction

  function automatic logic need_valc_f(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valc_f = 1'b1;
      default:                                     need_valc_f = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_fetch_stage_if.sv
// Fetch-stage bus: control/instruction bytes in, PC and decoded fields out.
// Optional instr_valid exists only with FETCH_ILLEGAL_CHECK_EN defined.
interface y86_fetch_stage_if #(
  parameter int PC_W = 32
);
  logic            en;
  logic            pc_load;
  logic [PC_W-1:0] pc_new;
  logic [79:0]     ibytes;
  logic [PC_W-1:0] pc;
  logic [3:0]      icode;
  logic [3:0]      ifun;
  logic [3:0]      rA;
  logic [3:0]      rB;
  logic [63:0]     valC;
  logic [PC_W-1:0] valP;
  logic            need_regids;
  logic            need_valC;
`ifdef FETCH_ILLEGAL_CHECK_EN
  logic            instr_valid;
`endif

  // master: pipeline control / instruction memory side
  modport master (
    output en, pc_load, pc_new, ibytes,
    input  pc, icode, ifun, rA, rB, valC, valP, need_regids, need_valC
`ifdef FETCH_ILLEGAL_CHECK_EN
    , input instr_valid
`endif
  );

  // slave: the fetch stage itself
  modport slave (
    input  en, pc_load, pc_new, ibytes,
    output pc, icode, ifun, rA, rB, valC, valP, need_regids, need_valC
`ifdef FETCH_ILLEGAL_CHECK_EN
    , output instr_valid
`endif
  );
endinterface

// File: rtl/y86_fetch_align.sv
// Register-specifier and little-endian constant-word extraction from the
// 10-byte fetch window; the window shifts by one byte when regids are present.
module y86_fetch_align
  import y86_pkg::*;
(
  input  logic [79:0] ibytes,
  input  logic        need_regids,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC
);
  logic [63:0] win;

  assign rA  = need_regids ? ibytes[71:68] : RNONE;
  assign rB  = need_regids ? ibytes[67:64] : RNONE;
  assign win = need_regids ? ibytes[63:0] : ibytes[71:8];

  // Lowest-address byte sits at the top of the window and lands in valC[7:0].
  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign valC[8*b +: 8] = win[63-8*b -: 8];
  end
endmodule

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: combinational split/decode/align/increment plus PC register.
// Define FETCH_ILLEGAL_CHECK_EN to add the instr_valid illegal-icode output.
module y86_fetch_stage
  import y86_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst_n,
  y86_fetch_stage_if.slave bus
);
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] valp;
  logic [3:0]      icode;
  logic            need_regids;
  logic            need_valc;

  assign icode       = bus.ibytes[79:76];
  assign need_regids = need_regids_f(icode);
  assign need_valc   = need_valc_f(icode);

  // Illegal icodes C..F already decode with both flags clear, so valP = pc+1.
  assign valp = pc_q + PC_W'(1) + PC_W'(need_regids)
              + (need_valc ? PC_W'(8) : '0);

  y86_fetch_align u_align (
    .ibytes      (bus.ibytes),
    .need_regids (need_regids),
    .rA          (bus.rA),
    .rB          (bus.rB),
    .valC        (bus.valC)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)           pc_q <= RESET_PC;
    else if (bus.pc_load) pc_q <= bus.pc_new;
    else if (bus.en)      pc_q <= valp;
  end

  assign bus.pc          = pc_q;
  assign bus.icode       = icode;
  assign bus.ifun        = bus.ibytes[75:72];
  assign bus.valP        = valp;
  assign bus.need_regids = need_regids;
  assign bus.need_valC   = need_valc;
`ifdef FETCH_ILLEGAL_CHECK_EN
  assign bus.instr_valid = (icode <= I_POPQ);
`endif
endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed bench for y86_fetch_stage with hand-computed expectations.
module tb_y86_fetch_stage;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  y86_fetch_stage_if #(.PC_W(PC_W)) bus ();

  y86_fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ld, input logic [PC_W-1:0] tgt);
    bus.en      = en;
    bus.pc_load = ld;
    bus.pc_new  = tgt;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ibytes = 80'h0;
    drive(1'b1, 1'b1, 32'h55);
    #1;
    step();
    chk("reset_pc", 64'(bus.pc), 64'h0);

    // irmovq $0x100, %rbx
    rst_n = 1'b1;
    drive(1'b1, 1'b0, '0);
    bus.ibytes = 80'h30F3_0001_0000_0000_0000;
    #1;
    chk("irm_icode", 64'(bus.icode), 64'h3);
    chk("irm_ifun",  64'(bus.ifun),  64'h0);
    chk("irm_rA",    64'(bus.rA),    64'hF);
    chk("irm_rB",    64'(bus.rB),    64'h3);
    chk("irm_valC",  bus.valC,       64'h100);
    chk("irm_valP",  64'(bus.valP),  64'h0A);
    step();
    chk("irm_pc",    64'(bus.pc),    64'h0A);

    // OPq %rdx,%rbx with trailing bytes: valC still deterministic
    bus.ibytes = 80'h6023_1122_3344_5566_7788;
    #1;
    chk("op_icode", 64'(bus.icode), 64'h6);
    chk("op_rA",    64'(bus.rA),    64'h2);
    chk("op_rB",    64'(bus.rB),    64'h3);
    chk("op_nvc",   64'(bus.need_valC), 64'h0);
    chk("op_valC",  bus.valC,       64'h8877_6655_4433_2211);
    chk("op_valP",  64'(bus.valP),  64'h0C);
    step();
    chk("op_pc",    64'(bus.pc),    64'h0C);

    // jXX 0x40 with pc_load and en together: pc_load wins
    bus.ibytes = 80'h7440_0000_0000_0000_0000;
    drive(1'b1, 1'b1, 32'h40);
    #1;
    chk("jxx_ifun", 64'(bus.ifun),  64'h4);
    chk("jxx_rA",   64'(bus.rA),    64'hF);
    chk("jxx_valC", bus.valC,       64'h40);
    chk("jxx_valP", 64'(bus.valP),  64'h15);
    step();
    chk("jxx_pc",   64'(bus.pc),    64'h40);

    // nop at 0x20
    drive(1'b0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b0, '0);
    bus.ibytes = 80'h1000_0000_0000_0000_0000;
    #1;
    chk("nop_pc",  64'(bus.pc),          64'h20);
    chk("nop_nrg", 64'(bus.need_regids), 64'h0);
    chk("nop_nvc", 64'(bus.need_valC),   64'h0);
    chk("nop_rA",  64'(bus.rA),          64'hF);
    chk("nop_rB",  64'(bus.rB),          64'hF);
    chk("nop_valP",64'(bus.valP),        64'h21);
    step();
    chk("hold_pc", 64'(bus.pc),          64'h20);

    // halt near the top of the address space: valP wraps
    drive(1'b0, 1'b1, 32'hFFFF_FFFE);
    bus.ibytes = 80'h0;
    step();
    drive(1'b1, 1'b0, '0);
    #1;
    chk("wrap_valP0", 64'(bus.valP), 64'hFFFF_FFFF);
    step();
    chk("wrap_pc1",   64'(bus.pc),   64'hFFFF_FFFF);
    chk("wrap_valP1", 64'(bus.valP), 64'h0);
    step();
    chk("wrap_pc2",   64'(bus.pc),   64'h0);

    // illegal icode C at pc=0
    drive(1'b0, 1'b0, '0);
    bus.ibytes = 80'hC012_3456_789A_BCDE_F012;
    #1;
    chk("ill_nrg",  64'(bus.need_regids), 64'h0);
    chk("ill_nvc",  64'(bus.need_valC),   64'h0);
    chk("ill_valP", 64'(bus.valP),        64'h1);
`ifdef FETCH_ILLEGAL_CHECK_EN
    chk("ill_valid", 64'(bus.instr_valid), 64'h0);
    bus.ibytes = 80'hB0F0_0000_0000_0000_0000;
    #1;
    chk("popq_valid", 64'(bus.instr_valid), 64'h1);
`endif

    // mid-stream reset discards pending valP (pushq -> valP would be 0x12)
    drive(1'b0, 1'b1, 32'h10);
    step();
    bus.ibytes = 80'hA0F0_0000_0000_0000_0000;
    drive(1'b1, 1'b0, '0);
    #1;
    chk("push_valP", 64'(bus.valP), 64'h12);
    rst_n = 1'b0;
    step();
    chk("midrst_pc", 64'(bus.pc),   64'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", 64'(bus.pc), 64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
